// File: rtl/store_unit_if.sv
// Memory write bus between the store unit (master) and the memory side (slave).
interface store_unit_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;

  modport master (
    output mem_req,
    output mem_addr,
    output mem_wdata,
    output mem_be,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    input  mem_wdata,
    input  mem_be,
    output mem_ack
  );
endinterface

// File: rtl/store_unit.sv
// Store unit: narrows a register value to byte/halfword/word, replicates it
// across the byte lanes, and issues one memory write with an ack timeout.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; request fields captured on the accepting edge
// REQ   | mem_req held with stable address/data/enables until ack or timeout
// DONE  | one-cycle completion pulse, qualified by misalign / timeout
module store_unit #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        misalign,
  output logic        timeout,
  store_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic        req_misaligned;
  logic [3:0]  lane_be;
  logic [31:0] lane_data;

  // Alignment check and lane steering for the request presented at the input.
  always_comb begin
    req_misaligned = 1'b0;
    lane_be        = 4'b0000;
    lane_data      = wdata;
    case (size)
      2'b00: begin
        lane_be   = 4'b0001 << addr[1:0];
        lane_data = {4{wdata[7:0]}};
      end
      2'b01: begin
        req_misaligned = addr[0];
        lane_be        = addr[1] ? 4'b1100 : 4'b0011;
        lane_data      = {2{wdata[15:0]}};
      end
      2'b10: begin
        req_misaligned = (addr[1:0] != 2'b00);
        lane_be        = 4'b1111;
        lane_data      = wdata;
      end
      default: begin
        req_misaligned = 1'b1;
      end
    endcase
  end

  // Sequencer with registered bus and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      wait_cnt      <= 8'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      misalign      <= 1'b0;
      timeout       <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_addr  <= 32'd0;
      bus.mem_wdata <= 32'd0;
      bus.mem_be    <= 4'b0000;
    end else begin
      done     <= 1'b0;
      misalign <= 1'b0;
      timeout  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (req_misaligned) begin
              state    <= DONE;
              done     <= 1'b1;
              misalign <= 1'b1;
            end else begin
              state         <= REQ;
              wait_cnt      <= 8'd0;
              bus.mem_req   <= 1'b1;
              bus.mem_addr  <= {addr[31:2], 2'b00};
              bus.mem_wdata <= lane_data;
              bus.mem_be    <= lane_be;
            end
          end
        end
        REQ: begin
          // Ack wins over a timeout landing on the same edge.
          if (bus.mem_ack) begin
            state       <= DONE;
            done        <= 1'b1;
            bus.mem_req <= 1'b0;
            bus.mem_be  <= 4'b0000;
          end else if (wait_cnt == TIMEOUT_CNT) begin
            state       <= DONE;
            done        <= 1'b1;
            timeout     <= 1'b1;
            bus.mem_req <= 1'b0;
            bus.mem_be  <= 4'b0000;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          busy        <= 1'b0;
          bus.mem_req <= 1'b0;
          bus.mem_be  <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: directed scenarios plus random stores
// compared against a lane/byte-level reference model.
module tb_store_unit;

  localparam int TO = 3;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        misalign;
  logic        timeout;

  int total;
  int bad;

  store_unit_if bus ();

  store_unit #(.TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .size     (size),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .misalign (misalign),
    .timeout  (timeout),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: number of bytes is 2**size, natural alignment required.
  function automatic logic model_mis(input logic [1:0] sz, input logic [31:0] a);
    int n;
    if (sz == 2'b11) return 1'b1;
    n = 1 << sz;
    return (a % n) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
    int n, off;
    logic [3:0] be;
    n   = 1 << sz;
    off = int'(a % 4);
    be  = 4'b0000;
    for (int i = 0; i < 4; i++)
      if (i >= off && i < off + n) be[i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] model_wd(input logic [1:0] sz, input logic [31:0] d);
    int n;
    logic [31:0] w;
    n = 1 << sz;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
    return w;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".req"}, bus.mem_req, 0);
    check({tag, ".be"}, bus.mem_be, 0);
  endtask

  // One store. ack_at: REQ cycle (1-based) on which mem_ack is raised, 0 = never.
  // hold_start keeps start high through REQ and DONE; ack_noise raises mem_ack in DONE.
  task automatic do_store(input string tag, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] d, input int ack_at, input bit hold_start,
                          input bit ack_noise);
    logic mis;
    int   last;
    bit   to_exp;
    mis    = model_mis(sz, a);
    to_exp = !(ack_at >= 1 && ack_at <= TO + 1);
    last   = to_exp ? TO + 1 : ack_at;
    @(negedge clk);
    start = 1'b1; size = sz; addr = a; wdata = d;
    bus.mem_ack = ack_noise;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    bus.mem_ack = 1'b0;
    if (!mis) begin
      for (int j = 1; j <= last; j++) begin
        check({tag, ".req"}, bus.mem_req, 1);
        check({tag, ".busy"}, busy, 1);
        check({tag, ".done_early"}, done, 0);
        check({tag, ".addr"}, bus.mem_addr, {a[31:2], 2'b00});
        check({tag, ".wdata"}, bus.mem_wdata, model_wd(sz, d));
        check({tag, ".be"}, bus.mem_be, model_be(sz, a));
        bus.mem_ack = (j == ack_at);
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
      end
    end
    check({tag, ".done"}, done, 1);
    check({tag, ".misalign"}, misalign, mis);
    check({tag, ".timeout"}, timeout, mis ? 1'b0 : to_exp);
    check({tag, ".req_off"}, bus.mem_req, 0);
    check({tag, ".be_off"}, bus.mem_be, 0);
    check({tag, ".busy_done"}, busy, 1);
    bus.mem_ack = ack_noise;
    @(posedge clk); #1;
    start = 1'b0;
    bus.mem_ack = 1'b0;
    check_idle({tag, ".after"});
    @(posedge clk); #1;
    check_idle({tag, ".after2"});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    size  = 2'b00;
    addr  = 32'd0;
    wdata = 32'd0;
    bus.mem_ack = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.misalign", misalign, 0);
    check("rst.timeout", timeout, 0);
    check("rst.req", bus.mem_req, 0);
    check("rst.be", bus.mem_be, 0);
    check("rst.addr", bus.mem_addr, 0);
    check("rst.wdata", bus.mem_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // ack while idle must be ignored
    bus.mem_ack = 1'b1;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    check_idle("idle_ack");

    do_store("byte",   2'b00, 32'h0000_1003, 32'h1234_56AB, 2, 0, 0);
    do_store("half",   2'b01, 32'h0000_0042, 32'hDEAD_BEEF, 1, 0, 0);
    do_store("mis_w",  2'b10, 32'h0000_0006, 32'hCAFE_F00D, 1, 0, 0);
    do_store("mis_r",  2'b11, $urandom,      $urandom,      1, 0, 0);
    do_store("mis_h",  2'b01, 32'h0000_0011, 32'h0BAD_0BAD, 1, 0, 0);
    do_store("tmo",    2'b10, 32'h0000_0100, 32'h1111_2222, 0, 0, 0);
    do_store("ack4",   2'b10, 32'h0000_0104, 32'h3333_4444, TO + 1, 0, 0);
    do_store("hold",   2'b00, 32'h0000_0202, 32'h0000_005A, 3, 1, 1);
    do_store("holdmis",2'b10, 32'h0000_0203, 32'h0000_005A, 1, 1, 1);

    // reset on the 2nd REQ cycle, with a coincident ack
    @(negedge clk);
    start = 1'b1; size = 2'b10; addr = 32'h0000_0400; wdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    check("rstreq.req1", bus.mem_req, 1);
    @(posedge clk); #1;
    check("rstreq.req2", bus.mem_req, 1);
    rst_n = 1'b0;
    bus.mem_ack = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    start = 1'b0;
    bus.mem_ack = 1'b0;
    check("rstreq.req", bus.mem_req, 0);
    check("rstreq.be", bus.mem_be, 0);
    check("rstreq.addr", bus.mem_addr, 0);
    check("rstreq.wdata", bus.mem_wdata, 0);
    check("rstreq.busy", busy, 0);
    check("rstreq.done", done, 0);
    check("rstreq.misalign", misalign, 0);
    check("rstreq.timeout", timeout, 0);
    @(posedge clk); #1;
    check_idle("rstreq.after");

    // random stores, biased towards aligned addresses
    for (int k = 0; k < 40; k++) begin
      logic [1:0]  rs;
      logic [31:0] ra;
      logic [31:0] rd;
      int          rk;
      rs = 2'($urandom_range(0, 3));
      ra = $urandom;
      rd = $urandom;
      if ($urandom_range(0, 3) != 0 && rs != 2'b11)
        ra = ra & ~((32'd1 << rs) - 32'd1);
      rk = int'($urandom_range(0, TO + 2));
      do_store("rand", rs, ra, rd, rk, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
